// File: rtl/nrf_spi_xfer_ctrl.sv
// SPI mode-0 master for an nRF24-style radio: framed multi-byte transfers with
// byte-granular abort, tx byte handshake and per-byte receive strobe.
module nrf_spi_xfer_ctrl #(
  parameter int HALF_DIV = 3,
  parameter int MAX_LEN  = 33
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] len,
  input  logic       abort,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       spi_csn,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int            CW       = $clog2(HALF_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(HALF_DIV - 2);
  localparam logic [5:0]    LEN_MAX  = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_half;
  logic [5:0]    r_rem;
  logic [6:0]    r_tx_sh;
  logic [7:0]    r_rx_sh;
  logic          r_abort;
  logic          r_tx_ack;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_csn;
  logic          r_sck;
  logic          r_mosi;

  logic          w_cnt_last;
  logic          w_abort_pend;
  logic          w_len_ok;
  logic [5:0]    w_rem_dec;

  assign w_cnt_last   = (r_cnt == CNT_LAST);
  // An abort arriving in the very last SHIFT cycle still stops the next byte.
  assign w_abort_pend = r_abort | abort;
  assign w_len_ok     = (len != 6'd0) && (len <= LEN_MAX);
  assign w_rem_dec    = r_rem - 6'd1;

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_half     <= 4'd0;
      r_rem      <= 6'd0;
      r_tx_sh    <= 7'd0;
      r_rx_sh    <= 8'd0;
      r_abort    <= 1'b0;
      r_tx_ack   <= 1'b0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_csn      <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_tx_ack   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;

      if (r_busy) begin
        if (abort) r_abort <= 1'b1;
      end else begin
        r_abort <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_half <= 4'd0;
          if (start && w_len_ok) begin
            r_rem   <= len;
            r_csn   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_cnt_last) begin
            r_cnt    <= '0;
            r_tx_ack <= 1'b1;
            r_state  <= S_LOAD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_LOAD: begin
          r_mosi  <= tx_data[7];
          r_tx_sh <= tx_data[6:0];
          r_cnt   <= '0;
          r_half  <= 4'd0;
          r_state <= S_SHIFT;
        end

        // Even half-periods are SCK low, odd ones SCK high; 16 halves per byte.
        S_SHIFT: begin
          if (w_cnt_last) begin
            r_cnt  <= '0;
            r_half <= r_half + 4'd1;
            if (!r_half[0]) begin
              r_sck   <= 1'b1;
              r_rx_sh <= {r_rx_sh[6:0], spi_miso};
            end else begin
              r_sck <= 1'b0;
              if (r_half != 4'd15) begin
                r_mosi  <= r_tx_sh[6];
                r_tx_sh <= {r_tx_sh[5:0], 1'b0};
              end
            end
            if (r_half == 4'd15) begin
              r_rx_data  <= r_rx_sh;
              r_rx_valid <= 1'b1;
              r_rem      <= w_rem_dec;
              if ((w_rem_dec != 6'd0) && !w_abort_pend) begin
                r_tx_ack <= 1'b1;
                r_state  <= S_LOAD;
              end else begin
                r_state <= S_HOLD;
              end
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_HOLD: begin
          if (w_cnt_last) begin
            r_cnt   <= '0;
            r_half  <= 4'd0;
            r_csn   <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        // Two half-periods of deselect; done is timed to land on the final cycle.
        S_GAP: begin
          if (w_cnt_last) begin
            r_cnt  <= '0;
            r_half <= r_half + 4'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (r_half[0] && (r_cnt == CNT_PRE)) r_done <= 1'b1;
          if (r_half[0] && w_cnt_last) begin
            r_half  <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_ack   = r_tx_ack;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign spi_csn  = r_csn;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;

endmodule
